coin_credit_decoder: RTL
========================

// Module: coin_credit_decoder
// PURPOSE
//  Receiving end of the coin encoder. Decodes the 2-bit coin code (00 none, 01 shilling, 10 florin, 11 crown).
//  Keeps a running credit in pence, vends on request and pays change back as one-hot coin pulses
//  (bit0 shilling, bit1 florin, bit2 crown), the same coin format the encoder accepts.
//  Sits between the coin encoder and the vending-machine dispense/change mechanics.
// PARAMETERS
//  SHILLING_VAL  12   pence credited for code 01
//  FLORIN_VAL    24   pence credited for code 10
//  CROWN_VAL     60   pence credited for code 11
//  PRICE         60   item price in pence
//  MAX_CREDIT    240  highest credit allowed; any coin that would exceed it is rejected
//  CREDIT_W      8    credit width; must hold MAX_CREDIT
// PORTS
//  clk            in   1         single clock, rising edge
//  rst_n          in   1         asynchronous active-low reset
//  encoded_value  in   2         coin code from encoder; held while the coin is present
//  vend_req       in   1         purchase request, sampled each cycle
//  cancel         in   1         refund request, sampled each cycle
//  credit         out  CREDIT_W  current credit in pence
//  vend           out  1         1-cycle dispense pulse
//  change_coins   out  3         one-hot change coin, 1-cycle pulse per coin
//  coin_reject    out  1         1-cycle pulse: coin not credited (return it)
//  busy           out  1         high in VEND or CHANGE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, credit=0, prev_code=00.
//   All outputs are 0 while in reset and in the first cycle after reset.
//  Coin edge: encoded_value!=00 and prev_code==00. prev_code is registered every cycle.
//   Exactly one credit per insertion, however many cycles the code is held.
//   A change from one nonzero code to another nonzero code is ignored; it is not an edge.
//  Credit update: the edge is credited at the next clock edge (latency 1).
//   Applies only in IDLE, and only if credit+value <= MAX_CREDIT.
//   Otherwise coin_reject pulses in that cycle and credit is unchanged.
//   A coin edge in VEND or CHANGE always gets coin_reject.
//  FSM states: IDLE, VEND, CHANGE.
//   IDLE, cancel=1:                            go to CHANGE; credit untouched.
//   IDLE, vend_req=1 and credit>=PRICE:        go to VEND.
//   IDLE, vend_req=1 and credit<PRICE:         ignored; stay in IDLE with no pulse.
//   vend_req and cancel together:              cancel wins.
//   Coin edge in the same cycle as the IDLE exit: the coin is still credited (in IDLE).
//   VEND (one cycle): vend=1; credit <= credit-PRICE.
//    Then go to CHANGE if credit-PRICE >= SHILLING_VAL, else to IDLE.
//   CHANGE: one coin per cycle, largest denomination <= remaining credit.
//    Order: crown, then florin, then shilling. change_coins pulses one-hot; credit drops by that value.
//    When remaining < SHILLING_VAL, go to IDLE and keep the residue in credit.
//    If remaining < SHILLING_VAL already on entry: go straight to IDLE, no pulse.
//    vend_req and cancel are ignored in VEND and CHANGE.
//  Arithmetic: unsigned CREDIT_W-bit. No wrap is possible: the add is gated by MAX_CREDIT,
//   and the subtract by the >= compares.
//  busy is combinational from state; vend, change_coins and coin_reject are registered pulses.
// CONFIGURATION
//  COIN_AUDIT_EN defined:
//   adds output audit_vends [15:0]: counts VEND cycles.
//   Saturates at 16'hFFFF; reset to 0 by rst_n only.
//  COIN_AUDIT_EN undefined: the port and the counter do not exist; all other behaviour is identical.
// TESTING
//  1. Florin code held 5 cycles, then 00 -> credit 0->24 once; no further increments.
//  2. Crown, then vend_req with credit=60
//     -> vend pulse 1 cycle; credit 0; back to IDLE; change_coins never pulses.
//  3. Crown+crown (credit 120), then vend_req
//     -> vend; then change_coins=100 for one cycle; credit 0; IDLE.
//  4. Credit 48, cancel -> change_coins 010 then 010 on consecutive cycles; credit 0; busy low after.
//  5. Credit 240, shilling inserted -> coin_reject pulse; credit stays 240.
//     Also: coin edge during CHANGE -> coin_reject.
//  6. rst_n low mid-CHANGE (credit 72)
//     -> immediately credit 0, IDLE, outputs 0; with COIN_AUDIT_EN, audit_vends=0.

Source files
------------

// File: rtl/coin_credit_decoder_if.sv
// rtl/coin_credit_decoder_if.sv - coin decoder bus: coin code and vend/cancel in, credit and pulses out
// Optional audit_vends signal exists only when COIN_AUDIT_EN is defined.
interface coin_credit_decoder_if #(
  parameter int CREDIT_W = 8
);
  logic [1:0]          encoded_value;
  logic                vend_req;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                vend;
  logic [2:0]          change_coins;
  logic                coin_reject;
  logic                busy;
`ifdef COIN_AUDIT_EN
  logic [15:0]         audit_vends;

  modport master (
    output encoded_value, vend_req, cancel,
    input  credit, vend, change_coins, coin_reject, busy, audit_vends
  );
  modport slave (
    input  encoded_value, vend_req, cancel,
    output credit, vend, change_coins, coin_reject, busy, audit_vends
  );
`else
  modport master (
    output encoded_value, vend_req, cancel,
    input  credit, vend, change_coins, coin_reject, busy
  );
  modport slave (
    input  encoded_value, vend_req, cancel,
    output credit, vend, change_coins, coin_reject, busy
  );
`endif
endinterface

// File: rtl/coin_credit_decoder.sv
// rtl/coin_credit_decoder.sv - coin credit accumulator with vend and greedy change payout
// Defining COIN_AUDIT_EN adds a saturating count of vends on audit_vends.
module coin_credit_decoder #(
  parameter int SHILLING_VAL = 12,
  parameter int FLORIN_VAL   = 24,
  parameter int CROWN_VAL    = 60,
  parameter int PRICE        = 60,
  parameter int MAX_CREDIT   = 240,
  parameter int CREDIT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  coin_credit_decoder_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] SHILL_C = CREDIT_W'(SHILLING_VAL);
  localparam logic [CREDIT_W-1:0] FLOR_C  = CREDIT_W'(FLORIN_VAL);
  localparam logic [CREDIT_W-1:0] CROWN_C = CREDIT_W'(CROWN_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          prev_code;
  logic                vend_q, vend_d;
  logic [2:0]          change_q, change_d;
  logic                reject_q, reject_d;

  logic                coin_edge;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] after_vend;

  // Only a rise from 00 counts; nonzero-to-nonzero code changes are not new coins.
  assign coin_edge  = (bus.encoded_value != 2'b00) && (prev_code == 2'b00);
  assign sum        = {1'b0, credit_q} + {1'b0, coin_val};
  assign after_vend = credit_q - PRICE_C;

  always_comb begin
    coin_val = '0;
    case (bus.encoded_value)
      2'b01:   coin_val = SHILL_C;
      2'b10:   coin_val = FLOR_C;
      2'b11:   coin_val = CROWN_C;
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = 1'b0;
    change_d = 3'b000;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_edge) begin
          if (sum <= MAX_C) credit_d = sum[CREDIT_W-1:0];
          else              reject_d = 1'b1;
        end
        if (bus.cancel) begin
          state_d = CHANGE;
        end else if (bus.vend_req && credit_q >= PRICE_C) begin
          state_d = VEND;
          vend_d  = 1'b1;
        end
      end
      VEND: begin
        reject_d = coin_edge;
        credit_d = after_vend;
        state_d  = (after_vend >= SHILL_C) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_edge;
        // Greedy payout, one coin per cycle; the sub-shilling residue stays as credit.
        if (credit_q >= CROWN_C) begin
          change_d = 3'b100;
          credit_d = credit_q - CROWN_C;
        end else if (credit_q >= FLOR_C) begin
          change_d = 3'b010;
          credit_d = credit_q - FLOR_C;
        end else if (credit_q >= SHILL_C) begin
          change_d = 3'b001;
          credit_d = credit_q - SHILL_C;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      prev_code <= 2'b00;
      vend_q    <= 1'b0;
      change_q  <= 3'b000;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      prev_code <= bus.encoded_value;
      vend_q    <= vend_d;
      change_q  <= change_d;
      reject_q  <= reject_d;
    end
  end

`ifdef COIN_AUDIT_EN
  logic [15:0] audit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     audit_q <= '0;
    else if (state_q == VEND && audit_q != 16'hFFFF) audit_q <= audit_q + 16'd1;
  end

  assign bus.audit_vends = audit_q;
`endif

  assign bus.credit       = credit_q;
  assign bus.vend         = vend_q;
  assign bus.change_coins = change_q;
  assign bus.coin_reject  = reject_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
